// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: stall vector, exception flush and redirect,
// deferred exceptions while MEM is stalled, and a data-bus watchdog.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR  = 32'h0000_0020,
  parameter int          BUS_TIMEOUT = 255,
  parameter int          TO_W        = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        except_valid,
  input  logic        except_eret,
  input  logic [31:0] cp0_epc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        bus_err,
  output logic [31:0] stall_cycles
);

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    PEND = 1'b1
  } state_t;

  localparam logic [TO_W-1:0] WD_LAST = TO_W'(BUS_TIMEOUT - 1);

  state_t            state_r, state_nxt_s;
  logic [TO_W-1:0]   watchdog_r, watchdog_nxt_s;
  logic              pend_eret_r;
  logic [31:0]       pend_epc_r;
  logic              bus_err_r;
  logic [31:0]       stall_cycles_r;
  logic              latch_s;
  logic              wd_fire_s;
  logic              flush_s;
  logic [31:0]       new_pc_s;
  logic [5:0]        stall_s;

  // A bus error outranks both live and pending exceptions.
  assign wd_fire_s = stallreq_mem && (watchdog_r == WD_LAST);

  // Next-state, flush and redirect decision.
  always_comb begin
    state_nxt_s = state_r;
    flush_s     = 1'b0;
    new_pc_s    = 32'h0000_0000;
    latch_s     = 1'b0;
    case (state_r)
      RUN: begin
        if (wd_fire_s) begin
          flush_s  = 1'b1;
          new_pc_s = EXC_VECTOR;
        end else if (except_valid && !stallreq_mem) begin
          flush_s  = 1'b1;
          new_pc_s = except_eret ? cp0_epc : EXC_VECTOR;
        end else if (except_valid) begin
          latch_s     = 1'b1;
          state_nxt_s = PEND;
        end else begin
          state_nxt_s = RUN;
        end
      end
      PEND: begin
        if (wd_fire_s) begin
          flush_s     = 1'b1;
          new_pc_s    = EXC_VECTOR;
          state_nxt_s = RUN;
        end else if (!stallreq_mem) begin
          flush_s     = 1'b1;
          new_pc_s    = pend_eret_r ? pend_epc_r : EXC_VECTOR;
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = PEND;
        end
      end
      default: begin
        state_nxt_s = RUN;
      end
    endcase
  end

  // Stall vector; MEM stall leaves WB draining.
  always_comb begin
    stall_s = 6'b000000;
    if (flush_s) begin
      stall_s = 6'b000000;
    end else if (stallreq_mem) begin
      stall_s = 6'b011111;
    end else if (stallreq_ex) begin
      stall_s = 6'b001111;
    end else if (stallreq_id) begin
      stall_s = 6'b000111;
    end else begin
      stall_s = 6'b000000;
    end
  end

  // Watchdog counts consecutive unflushed MEM stall cycles.
  always_comb begin
    watchdog_nxt_s = '0;
    if (!stallreq_mem || flush_s) begin
      watchdog_nxt_s = '0;
    end else begin
      watchdog_nxt_s = watchdog_r + TO_W'(1);
    end
  end

  // State, pending exception, watchdog and statistics registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= RUN;
      watchdog_r     <= '0;
      pend_eret_r    <= 1'b0;
      pend_epc_r     <= 32'h0000_0000;
      bus_err_r      <= 1'b0;
      stall_cycles_r <= 32'h0000_0000;
    end else begin
      state_r    <= state_nxt_s;
      watchdog_r <= watchdog_nxt_s;
      bus_err_r  <= wd_fire_s;
      if (latch_s) begin
        pend_eret_r <= except_eret;
        pend_epc_r  <= cp0_epc;
      end
      if ((stall_s != 6'b000000) && (stall_cycles_r != 32'hFFFF_FFFF)) begin
        stall_cycles_r <= stall_cycles_r + 32'd1;
      end
    end
  end

  assign stall        = stall_s;
  assign flush        = flush_s;
  assign new_pc       = new_pc_s;
  assign bus_err      = bus_err_r;
  assign stall_cycles = stall_cycles_r;

  pipe_ctrl_chk u_chk (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush_s),
    .stall   (stall_s)
  );

endmodule

// Checker: a flush cycle never holds any pipeline register.
module pipe_ctrl_chk (
  input logic       clk,
  input logic       reset_n,
  input logic       flush,
  input logic [5:0] stall
);

  a_flush_no_stall: assert property (@(posedge clk) disable iff (!reset_n)
    flush |-> (stall == 6'b000000));

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus random traffic checked against
// a cycle-level behavioural model of the controller rules.
module tb_pipe_ctrl;

  localparam logic [31:0] VEC = 32'h0000_0020;
  localparam int          TO_B = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        id = 1'b0, ex = 1'b0, mem = 1'b0, ev = 1'b0, er = 1'b0;
  logic [31:0] epc = 32'h0;

  logic [5:0]  stall_a, stall_b;
  logic        flush_a, flush_b, bus_err_a, bus_err_b;
  logic [31:0] new_pc_a, new_pc_b, cyc_a, cyc_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state (abstract view of the controller)
  bit          m_pend, m_pend_eret, m_buserr;
  logic [31:0] m_pend_epc;
  int          m_run;
  longint      m_cycles;

  always #5 clk = ~clk;

  pipe_ctrl u_dut_a (
    .clk(clk), .reset_n(reset_n), .stallreq_id(id), .stallreq_ex(ex),
    .stallreq_mem(mem), .except_valid(ev), .except_eret(er), .cp0_epc(epc),
    .stall(stall_a), .flush(flush_a), .new_pc(new_pc_a), .bus_err(bus_err_a),
    .stall_cycles(cyc_a)
  );

  pipe_ctrl #(.BUS_TIMEOUT(TO_B)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .stallreq_id(id), .stallreq_ex(ex),
    .stallreq_mem(mem), .except_valid(ev), .except_eret(er), .cp0_epc(epc),
    .stall(stall_b), .flush(flush_b), .new_pc(new_pc_b), .bus_err(bus_err_b),
    .stall_cycles(cyc_b)
  );

  task automatic clear_inputs();
    id = 1'b0; ex = 1'b0; mem = 1'b0; ev = 1'b0; er = 1'b0; epc = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    #12;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 1'b0;
    #12;
    n_checks++;
    if (cyc_a !== 32'd0) begin n_fail++; $display("FAIL reset_cycles got %h want 0", cyc_a); end
    n_checks++;
    if (bus_err_a !== 1'b0) begin n_fail++; $display("FAIL reset_bus_err got %b want 0", bus_err_a); end
    n_checks++;
    if (stall_a !== 6'b0 || flush_a !== 1'b0 || new_pc_a !== 32'h0) begin
      n_fail++; $display("FAIL reset_comb got stall=%b flush=%b pc=%h want 0", stall_a, flush_a, new_pc_a);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_stall_priority();
    logic [5:0] exp [3];
    exp[0] = 6'b000111; exp[1] = 6'b001111; exp[2] = 6'b011111;
    for (int i = 0; i < 3; i++) begin
      id = 1'b1; ex = (i >= 1); mem = (i >= 2);
      @(negedge clk);
      n_checks++;
      if (stall_a !== exp[i] || flush_a !== 1'b0) begin
        n_fail++; $display("FAIL stall_prio%0d got %b/%b want %b/0", i, stall_a, flush_a, exp[i]);
      end
      tick();
    end
    n_checks++;
    if (cyc_a !== 32'd3) begin n_fail++; $display("FAIL stall_cycles got %0d want 3", cyc_a); end
    clear_inputs();
    tick();
  endtask

  task automatic test_immediate_exc();
    ev = 1'b1; er = 1'b0; epc = 32'h5555_0000;
    @(negedge clk);
    n_checks++;
    if (flush_a !== 1'b1 || new_pc_a !== VEC || stall_a !== 6'b0) begin
      n_fail++; $display("FAIL imm_exc got flush=%b pc=%h stall=%b want 1/%h/0", flush_a, new_pc_a, stall_a, VEC);
    end
    tick();
    clear_inputs();
    @(negedge clk);
    n_checks++;
    if (flush_a !== 1'b0) begin n_fail++; $display("FAIL imm_exc_after got flush=%b want 0", flush_a); end
    tick();
  endtask

  task automatic test_eret();
    ev = 1'b1; er = 1'b1; epc = 32'h0000_1234;
    @(negedge clk);
    n_checks++;
    if (flush_a !== 1'b1 || new_pc_a !== 32'h0000_1234) begin
      n_fail++; $display("FAIL eret got flush=%b pc=%h want 1/00001234", flush_a, new_pc_a);
    end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_deferred();
    for (int c = 1; c <= 5; c++) begin
      mem = 1'b1;
      ev  = (c == 1) || (c == 3);
      er  = (c == 1);
      epc = (c == 1) ? 32'h0000_ABCD : 32'h0;
      @(negedge clk);
      n_checks++;
      if (flush_a !== 1'b0 || stall_a !== 6'b011111) begin
        n_fail++; $display("FAIL defer_c%0d got flush=%b stall=%b want 0/011111", c, flush_a, stall_a);
      end
      tick();
    end
    clear_inputs();
    @(negedge clk);
    n_checks++;
    if (flush_a !== 1'b1 || new_pc_a !== 32'h0000_ABCD || stall_a !== 6'b0) begin
      n_fail++; $display("FAIL defer_flush got flush=%b pc=%h stall=%b want 1/0000abcd/0", flush_a, new_pc_a, stall_a);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (flush_a !== 1'b0) begin n_fail++; $display("FAIL defer_after got flush=%b want 0", flush_a); end
    tick();
  endtask

  task automatic test_watchdog();
    mem = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (stall_b !== 6'b011111 || flush_b !== 1'b0) begin
        n_fail++; $display("FAIL wd_c%0d got stall=%b flush=%b want 011111/0", c, stall_b, flush_b);
      end
      tick();
    end
    @(negedge clk);
    n_checks++;
    if (flush_b !== 1'b1 || stall_b !== 6'b0 || new_pc_b !== VEC || bus_err_b !== 1'b0) begin
      n_fail++; $display("FAIL wd_fire got flush=%b stall=%b pc=%h berr=%b want 1/0/%h/0", flush_b, stall_b, new_pc_b, bus_err_b, VEC);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (bus_err_b !== 1'b1 || flush_b !== 1'b0 || stall_b !== 6'b011111) begin
      n_fail++; $display("FAIL wd_buserr got berr=%b flush=%b stall=%b want 1/0/011111", bus_err_b, flush_b, stall_b);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (bus_err_b !== 1'b0 || flush_b !== 1'b0) begin
      n_fail++; $display("FAIL wd_restart got berr=%b flush=%b want 0/0", bus_err_b, flush_b);
    end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_in_pend();
    mem = 1'b1; ev = 1'b1; er = 1'b0;
    tick();
    ev = 1'b0;
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (cyc_a !== 32'd0 || bus_err_a !== 1'b0) begin
      n_fail++; $display("FAIL rst_pend_async got cycles=%0d berr=%b want 0/0", cyc_a, bus_err_a);
    end
    clear_inputs();
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    @(negedge clk);
    n_checks++;
    if (flush_a !== 1'b0 || stall_a !== 6'b0 || cyc_a !== 32'd0) begin
      n_fail++; $display("FAIL rst_pend_release got flush=%b stall=%b cycles=%0d want 0/0/0", flush_a, stall_a, cyc_a);
    end
    tick();
  endtask

  // Random traffic on the short-timeout instance against the model.
  task automatic test_random();
    bit          fire, e_flush;
    logic [31:0] e_pc;
    logic [5:0]  e_stall;
    do_reset();
    m_pend = 1'b0; m_pend_eret = 1'b0; m_pend_epc = 32'h0;
    m_run = 0; m_buserr = 1'b0; m_cycles = 0;
    for (int n = 0; n < 400; n++) begin
      id  = ($urandom_range(0, 3) == 0);
      ex  = ($urandom_range(0, 3) == 0);
      mem = ($urandom_range(0, 9) < 6);
      ev  = ($urandom_range(0, 4) == 0);
      er  = $urandom_range(0, 1);
      epc = $urandom;
      @(negedge clk);
      fire    = mem && (m_run == TO_B - 1);
      e_flush = 1'b0;
      e_pc    = VEC;
      if (fire) begin
        e_flush = 1'b1;
        m_pend  = 1'b0;
      end else if (m_pend) begin
        if (!mem) begin
          e_flush = 1'b1;
          e_pc    = m_pend_eret ? m_pend_epc : VEC;
          m_pend  = 1'b0;
        end
      end else if (ev) begin
        if (!mem) begin
          e_flush = 1'b1;
          e_pc    = er ? epc : VEC;
        end else begin
          m_pend = 1'b1; m_pend_eret = er; m_pend_epc = epc;
        end
      end
      e_stall = e_flush ? 6'b000000 : mem ? 6'b011111 : ex ? 6'b001111 : id ? 6'b000111 : 6'b000000;
      n_checks++;
      if (flush_b !== e_flush || stall_b !== e_stall || (e_flush && new_pc_b !== e_pc)) begin
        n_fail++;
        $display("FAIL rand%0d_comb got flush=%b stall=%b pc=%h want %b/%b/%h", n, flush_b, stall_b, new_pc_b, e_flush, e_stall, e_pc);
      end
      n_checks++;
      if (bus_err_b !== m_buserr || cyc_b !== m_cycles[31:0]) begin
        n_fail++;
        $display("FAIL rand%0d_reg got berr=%b cycles=%0d want %b/%0d", n, bus_err_b, cyc_b, m_buserr, m_cycles);
      end
      m_buserr = fire;
      m_run    = (mem && !e_flush) ? m_run + 1 : 0;
      if (e_stall != 6'b0 && m_cycles < 64'hFFFF_FFFF) m_cycles++;
      tick();
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_stall_priority();
    test_immediate_exc();
    test_eret();
    test_deferred();
    test_watchdog();
    test_reset_in_pend();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
